edge_point_extract: RTL and testbench
=====================================

EDGE_POINT_EXTRACT -- requirements
Module: edge_point_extract

Interface
REQ-001 Parameter THRESHOLD, default 128: pixel value at or above which a pixel is an edge point.
REQ-002 Parameter FIFO_DEPTH, default 16: point FIFO depth; SHALL be a power of 2, minimum 2.
REQ-003 Clk  input  1  system clock; all state changes on the rising edge.
REQ-004 nReset  input  1  asynchronous active-low reset.
REQ-005 PixelIn  input  8  pixel from the edge-detection stage; valid every cycle after the first FrameIn.
REQ-006 FrameIn  input  1  one-cycle pulse, coincident with the first pixel of a frame.
REQ-007 LineIn  input  1  one-cycle pulse, coincident with the first pixel of each line.
REQ-008 PointX  output  8  column of the head-of-FIFO edge point.
REQ-009 PointY  output  8  row of the head-of-FIFO edge point.
REQ-010 PointValid  output  1  FIFO non-empty; PointX/PointY are valid.
REQ-011 PointReady  input  1  consumer accepts the point; pop when PointValid and PointReady are both high.
REQ-012 Overflow  output  1  sticky flag: an edge point was dropped in the current frame.
REQ-013 FrameDone  output  1  one-cycle pulse marking the end of the previous frame.

Function
REQ-014 The block SHALL ignore all input pixels until the first FrameIn after reset.
REQ-015 The column counter SHALL load 0 on any cycle with FrameIn or LineIn; otherwise it increments per pixel and saturates at 255.
REQ-016 The row counter SHALL load 0 on FrameIn; otherwise it increments on LineIn and saturates at 255.
REQ-017 When FrameIn and LineIn are asserted together, the block SHALL treat the cycle as a frame start only.
REQ-018 A pixel SHALL be an edge point when PixelIn >= THRESHOLD (unsigned 8-bit compare).
REQ-019 Each edge point's (column, row) SHALL be registered on the sampling edge and written to the FIFO on the next rising edge.
REQ-020 PointValid SHALL be high in the cycle after the FIFO write when the FIFO was empty (2-edge latency from pixel sample).
REQ-021 The FIFO SHALL be first-word-fall-through: PointX/PointY reflect the head entry whenever PointValid is high.
REQ-022 Push and pop in the same cycle SHALL both take effect, including when the FIFO is full; occupancy is then unchanged.
REQ-023 A push to a full FIFO without a simultaneous pop SHALL be dropped and SHALL set Overflow.
REQ-024 Overflow SHALL clear on FrameIn, unless a drop occurs in the same cycle, in which case it SHALL stay set.
REQ-025 FrameDone SHALL pulse for one cycle on every FrameIn except the first after reset.
REQ-026 FrameIn SHALL NOT flush the FIFO; points from the previous frame drain in order.
REQ-027 FIFO read and write pointers SHALL be log2(FIFO_DEPTH)+1 bits wide, with the MSB used for the full/empty distinction.
REQ-028 PointX and PointY SHALL hold their value while PointValid is high and PointReady is low.

Reset
REQ-029 On nReset low, all of the following SHALL clear to 0 immediately: counters, FIFO pointers, PointValid, Overflow, FrameDone, PointX, PointY and the frame-seen flag.
REQ-030 Reset asserted mid-frame SHALL discard all FIFO contents; after release, the block waits for the next FrameIn.

Configuration
REQ-031 Macro EDGE_POINT_STATS_EN: when defined, the block SHALL add the output PointCount (16 bits).
- PointCount SHALL be latched on each FrameDone with the number of edge points detected in the completed frame, including dropped points.
- The count SHALL saturate at 65535 and SHALL reset to 0.
REQ-032 Without EDGE_POINT_STATS_EN, the PointCount port and its counter SHALL be absent, with no other change in behaviour.

Verification
REQ-033 Scenario: 4x4 frame, PixelIn=200 only at (x2,y1), PointReady=1 -> a single pop of (2,1); PointValid high exactly one cycle, 2 edges after the sample.
REQ-034 Scenario: 1x20 line of PixelIn=255, PointReady=0 -> FIFO holds points x0..x15; Overflow set when x16 arrives; then PointReady=1 -> pops x0..x15 in order.
REQ-035 Scenario: FIFO full, PointReady=1 and an edge pixel in the same cycle -> no drop, Overflow stays 0, occupancy stays 16.
REQ-036 Scenario: PixelIn=127 then 128 with THRESHOLD=128 -> only the 128 pixel produces a point.
REQ-037 Scenario: two frames, nReset pulsed low mid-second frame -> PointValid=0 immediately; no FrameDone until two FrameIn pulses have occurred after release.
REQ-038 Scenario: STATS_EN build, frame with 300 edge pixels and 16-deep FIFO stalled -> PointCount=300 after the next FrameIn, and Overflow=1 before that FrameIn.

Source files
------------

// File: rtl/edge_point_extract.sv
// Purpose : turns an edge-detected pixel stream into a queue of (column,row) edge points.
// Latency : pixel sampled on edge N, point written to the FIFO on edge N+1, PointValid after N+1.
// Backpres: point FIFO (first-word-fall-through) stalls on PointReady=0; pushes to a full FIFO
//           without a simultaneous pop are dropped and flagged on the sticky Overflow output.
// Ports   : Clk/nReset (async active-low); PixelIn/FrameIn/LineIn pixel stream;
//           PointX/PointY/PointValid/PointReady point stream; Overflow, FrameDone status.
// Option  : define EDGE_POINT_STATS_EN to add PointCount, the per-frame edge point total.
module edge_point_extract #(
  parameter int unsigned THRESHOLD  = 128,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic       Clk,
  input  logic       nReset,
  input  logic [7:0] PixelIn,
  input  logic       FrameIn,
  input  logic       LineIn,
  output logic [7:0] PointX,
  output logic [7:0] PointY,
  output logic       PointValid,
  input  logic       PointReady,
  output logic       Overflow,
  output logic       FrameDone
`ifdef EDGE_POINT_STATS_EN
  ,
  output logic [15:0] PointCount
`endif
);

  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam logic [7:0]  THR = 8'(THRESHOLD);

  logic          frame_seen_q, frame_seen_d;
  logic [7:0]    col_q, col_d;
  logic [7:0]    row_q, row_d;
  logic          pt_vld_q, pt_vld_d;
  logic [7:0]    pt_x_q, pt_y_q;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          overflow_q, overflow_d;
  logic          frame_done_q, frame_done_d;
  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [15:0]   head;

  logic          is_edge;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push_ok;
  logic          drop;

  always_comb begin
    frame_seen_d = frame_seen_q | FrameIn;
    // Pixels only count once a frame has started; FrameIn's own pixel belongs to the new frame.
    is_edge      = (FrameIn || frame_seen_q) && (PixelIn >= THR);
    pt_vld_d     = is_edge;

    col_d = col_q;
    row_d = row_q;
    if (FrameIn) begin
      // FrameIn wins over a coincident LineIn: the row must restart at 0, not 1.
      col_d = 8'd0;
      row_d = 8'd0;
    end else if (frame_seen_q) begin
      if (LineIn) begin
        col_d = 8'd0;
        row_d = (row_q == 8'hFF) ? row_q : row_q + 8'd1;
      end else begin
        col_d = (col_q == 8'hFF) ? col_q : col_q + 8'd1;
      end
    end

    // Extra pointer MSB distinguishes full (MSBs differ) from empty (pointers equal).
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop     = !empty && PointReady;
    // A pop frees the head slot this same edge, so a full FIFO can still accept the push.
    push_ok = pt_vld_q && (!full || pop);
    drop    = pt_vld_q && full && !pop;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;

    // A drop on the FrameIn cycle is still reported for the frame that is starting.
    if (drop)         overflow_d = 1'b1;
    else if (FrameIn) overflow_d = 1'b0;
    else              overflow_d = overflow_q;

    frame_done_d = FrameIn && frame_seen_q;
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      frame_seen_q <= 1'b0;
      col_q        <= 8'd0;
      row_q        <= 8'd0;
      pt_vld_q     <= 1'b0;
      pt_x_q       <= 8'd0;
      pt_y_q       <= 8'd0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_seen_q <= frame_seen_d;
      col_q        <= col_d;
      row_q        <= row_d;
      pt_vld_q     <= pt_vld_d;
      pt_x_q       <= col_d;
      pt_y_q       <= row_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Storage needs no reset: entries are only visible while the pointers say they are valid.
  always_ff @(posedge Clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= {pt_x_q, pt_y_q};
  end

  assign head       = mem_q[rd_ptr_q[AW-1:0]];
  assign PointValid = !empty;
  // Gated so the point outputs read 0 in reset and whenever the FIFO is empty.
  assign PointX     = PointValid ? head[15:8] : 8'd0;
  assign PointY     = PointValid ? head[7:0]  : 8'd0;
  assign Overflow   = overflow_q;
  assign FrameDone  = frame_done_q;

`ifdef EDGE_POINT_STATS_EN
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] point_count_q, point_count_d;

  always_comb begin
    cnt_d         = cnt_q;
    point_count_d = point_count_q;
    if (FrameIn) begin
      // Publish the completed frame's total; FrameIn's own pixel starts the new count.
      if (frame_seen_q) point_count_d = cnt_q;
      cnt_d = is_edge ? 16'd1 : 16'd0;
    end else if (is_edge && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      cnt_q         <= 16'd0;
      point_count_q <= 16'd0;
    end else begin
      cnt_q         <= cnt_d;
      point_count_q <= point_count_d;
    end
  end

  assign PointCount = point_count_q;
`endif

endmodule

// File: tb/tb_edge_point_extract.sv
module tb_edge_point_extract;

  logic       Clk = 1'b0;
  logic       nReset;
  logic [7:0] PixelIn;
  logic       FrameIn;
  logic       LineIn;
  logic [7:0] PointX;
  logic [7:0] PointY;
  logic       PointValid;
  logic       PointReady;
  logic       Overflow;
  logic       FrameDone;
`ifdef EDGE_POINT_STATS_EN
  logic [15:0] PointCount;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  edge_point_extract #(.THRESHOLD(128), .FIFO_DEPTH(16)) dut (
    .Clk        (Clk),
    .nReset     (nReset),
    .PixelIn    (PixelIn),
    .FrameIn    (FrameIn),
    .LineIn     (LineIn),
    .PointX     (PointX),
    .PointY     (PointY),
    .PointValid (PointValid),
    .PointReady (PointReady),
    .Overflow   (Overflow),
    .FrameDone  (FrameDone)
`ifdef EDGE_POINT_STATS_EN
    ,
    .PointCount (PointCount)
`endif
  );

  always #5 Clk = ~Clk;

  // One pixel per call: inputs are presented, sampled on the next rising edge,
  // and the task returns 1 time unit after that edge so outputs can be inspected.
  task automatic pix(input logic [7:0] p, input logic f, input logic l);
    PixelIn = p;
    FrameIn = f;
    LineIn  = l;
    @(posedge Clk);
    #1;
    FrameIn = 1'b0;
    LineIn  = 1'b0;
  endtask

  task automatic test_reset;
    int hi;
    nReset = 1'b0; PixelIn = 8'd0; FrameIn = 1'b0; LineIn = 1'b0; PointReady = 1'b0;
    #3;
    n_cmp++; if (PointValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", PointValid); end
    n_cmp++; if (PointX !== 8'd0) begin n_fail++; $display("FAIL reset_x: got %0d want 0", PointX); end
    n_cmp++; if (PointY !== 8'd0) begin n_fail++; $display("FAIL reset_y: got %0d want 0", PointY); end
    n_cmp++; if (Overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %0b want 0", Overflow); end
    n_cmp++; if (FrameDone !== 1'b0) begin n_fail++; $display("FAIL reset_fd: got %0b want 0", FrameDone); end
    @(posedge Clk); #1;
    nReset = 1'b1;
    // Edge pixels and LineIn before any FrameIn must be ignored.
    hi = 0;
    pix(8'd255, 1'b0, 1'b1);
    if (PointValid) hi++;
    repeat (4) begin
      pix(8'd255, 1'b0, 1'b0);
      if (PointValid) hi++;
    end
    n_cmp++; if (hi !== 0) begin n_fail++; $display("FAIL pre_frame_ignored: got %0d valid cycles want 0", hi); end
  endtask

  // 4x4 frame, one edge pixel at (2,1); FrameIn and LineIn together on the first pixel.
  task automatic test_single_point;
    int hi, first_idx, idx;
    logic [7:0] hx, hy;
    logic fd_seen;
    PointReady = 1'b1;
    hi = 0; first_idx = -1; hx = 8'd0; hy = 8'd0; fd_seen = 1'b0; idx = 0;
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 4; x++) begin
        pix((x == 2 && y == 1) ? 8'd200 : 8'd10, (x == 0 && y == 0), (x == 0));
        if (FrameDone) fd_seen = 1'b1;
        if (PointValid) begin
          hi++;
          if (first_idx < 0) begin first_idx = idx; hx = PointX; hy = PointY; end
        end
        idx++;
      end
    end
    repeat (3) begin
      pix(8'd0, 1'b0, 1'b0);
      if (PointValid) hi++;
    end
    n_cmp++; if (hi !== 1) begin n_fail++; $display("FAIL single_valid_cycles: got %0d want 1", hi); end
    n_cmp++; if (first_idx !== 7) begin n_fail++; $display("FAIL single_latency: got call %0d want 7", first_idx); end
    n_cmp++; if (hx !== 8'd2) begin n_fail++; $display("FAIL single_x: got %0d want 2", hx); end
    n_cmp++; if (hy !== 8'd1) begin n_fail++; $display("FAIL single_y: got %0d want 1", hy); end
    n_cmp++; if (fd_seen !== 1'b0) begin n_fail++; $display("FAIL first_frame_no_done: got %0b want 0", fd_seen); end
  endtask

  task automatic test_threshold;
    PointReady = 1'b1;
    pix(8'd127, 1'b1, 1'b0);
    n_cmp++; if (FrameDone !== 1'b1) begin n_fail++; $display("FAIL thr_frame_done: got %0b want 1", FrameDone); end
    pix(8'd128, 1'b0, 1'b0);
    n_cmp++; if (FrameDone !== 1'b0) begin n_fail++; $display("FAIL thr_frame_done_pulse: got %0b want 0", FrameDone); end
    n_cmp++; if (PointValid !== 1'b0) begin n_fail++; $display("FAIL thr_127_no_point: got %0b want 0", PointValid); end
    pix(8'd0, 1'b0, 1'b0);
    n_cmp++; if (PointValid !== 1'b1) begin n_fail++; $display("FAIL thr_128_point: got %0b want 1", PointValid); end
    n_cmp++; if (PointX !== 8'd1 || PointY !== 8'd0) begin n_fail++; $display("FAIL thr_128_xy: got %0d,%0d want 1,0", PointX, PointY); end
    pix(8'd0, 1'b0, 1'b0);
    n_cmp++; if (PointValid !== 1'b0) begin n_fail++; $display("FAIL thr_single_pop: got %0b want 0", PointValid); end
  endtask

  // 1x20 line of 255 with the consumer stalled; then drop on the next FrameIn edge.
  task automatic test_overflow;
    PointReady = 1'b0;
    for (int k = 0; k < 20; k++) begin
      pix(8'd255, (k == 0), 1'b0);
      if (k == 16) begin
        n_cmp++; if (Overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_not_yet: got %0b want 0", Overflow); end
      end
      if (k == 17) begin
        n_cmp++; if (Overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set_x16: got %0b want 1", Overflow); end
      end
    end
    // x19 is pushed into the full FIFO on this FrameIn edge: Overflow must stay set.
    pix(8'd0, 1'b1, 1'b0);
    n_cmp++; if (Overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_drop_on_framein: got %0b want 1", Overflow); end
    PointReady = 1'b1;
    for (int k = 0; k < 16; k++) begin
      n_cmp++;
      if (PointValid !== 1'b1 || PointX !== 8'(k) || PointY !== 8'd0) begin
        n_fail++; $display("FAIL ovf_drain_%0d: got v=%0b x=%0d y=%0d want v=1 x=%0d y=0", k, PointValid, PointX, PointY, k);
      end
      pix(8'd0, 1'b0, 1'b0);
    end
    n_cmp++; if (PointValid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained_empty: got %0b want 0", PointValid); end
    n_cmp++; if (Overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %0b want 1", Overflow); end
  endtask

  // Full FIFO with a push and pop on the same edge: nothing dropped, occupancy stays 16.
  task automatic test_full_push_pop;
    PointReady = 1'b0;
    for (int k = 0; k < 17; k++) begin
      pix(8'd255, (k == 0), 1'b0);
      if (k == 0) begin
        n_cmp++; if (Overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear_on_frame: got %0b want 0", Overflow); end
      end
    end
    n_cmp++; if (PointValid !== 1'b1 || PointX !== 8'd0) begin n_fail++; $display("FAIL full_head: got v=%0b x=%0d want v=1 x=0", PointValid, PointX); end
    PointReady = 1'b1;
    pix(8'd0, 1'b0, 1'b0);
    PointReady = 1'b0;
    pix(8'd0, 1'b0, 1'b0);
    n_cmp++; if (Overflow !== 1'b0) begin n_fail++; $display("FAIL full_push_pop_no_drop: got %0b want 0", Overflow); end
    PointReady = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      n_cmp++;
      if (PointValid !== 1'b1 || PointX !== 8'(k)) begin
        n_fail++; $display("FAIL full_drain_%0d: got v=%0b x=%0d want v=1 x=%0d", k, PointValid, PointX, k);
      end
      pix(8'd0, 1'b0, 1'b0);
    end
    n_cmp++; if (PointValid !== 1'b0) begin n_fail++; $display("FAIL full_occupancy_16: got %0b want 0", PointValid); end
  endtask

  // 300-pixel line, edge only on the last pixel: column must have saturated at 255.
  task automatic test_saturation;
    PointReady = 1'b1;
    for (int k = 0; k < 300; k++) pix((k == 299) ? 8'd255 : 8'd0, (k == 0), 1'b0);
    pix(8'd0, 1'b0, 1'b0);
    n_cmp++; if (PointValid !== 1'b1) begin n_fail++; $display("FAIL sat_valid: got %0b want 1", PointValid); end
    n_cmp++; if (PointX !== 8'd255 || PointY !== 8'd0) begin n_fail++; $display("FAIL sat_xy: got %0d,%0d want 255,0", PointX, PointY); end
    pix(8'd0, 1'b0, 1'b0);
    n_cmp++; if (PointValid !== 1'b0) begin n_fail++; $display("FAIL sat_pop: got %0b want 0", PointValid); end
  endtask

  task automatic test_reset_mid;
    int hi;
    PointReady = 1'b0;
    pix(8'd255, 1'b1, 1'b0);
    pix(8'd0, 1'b0, 1'b0);
    pix(8'd0, 1'b0, 1'b0);
    pix(8'd255, 1'b1, 1'b0);
    pix(8'd255, 1'b0, 1'b0);
    pix(8'd0, 1'b0, 1'b0);
    n_cmp++; if (PointValid !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre_valid: got %0b want 1", PointValid); end
    #2 nReset = 1'b0;
    #1;
    n_cmp++; if (PointValid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %0b want 0", PointValid); end
    n_cmp++; if (PointX !== 8'd0) begin n_fail++; $display("FAIL rst_mid_x: got %0d want 0", PointX); end
    @(posedge Clk); #1;
    nReset = 1'b1;
    hi = 0;
    pix(8'd255, 1'b0, 1'b1);
    if (PointValid) hi++;
    repeat (3) begin
      pix(8'd255, 1'b0, 1'b0);
      if (PointValid) hi++;
    end
    n_cmp++; if (hi !== 0) begin n_fail++; $display("FAIL rst_mid_wait_frame: got %0d valid cycles want 0", hi); end
    pix(8'd255, 1'b1, 1'b0);
    n_cmp++; if (FrameDone !== 1'b0) begin n_fail++; $display("FAIL rst_mid_first_frame_done: got %0b want 0", FrameDone); end
    pix(8'd0, 1'b0, 1'b0);
    pix(8'd0, 1'b0, 1'b0);
    n_cmp++; if (PointValid !== 1'b1 || PointX !== 8'd0 || PointY !== 8'd0) begin n_fail++; $display("FAIL rst_mid_point: got v=%0b x=%0d y=%0d want 1,0,0", PointValid, PointX, PointY); end
    pix(8'd0, 1'b1, 1'b0);
    n_cmp++; if (FrameDone !== 1'b1) begin n_fail++; $display("FAIL rst_mid_second_frame_done: got %0b want 1", FrameDone); end
    PointReady = 1'b1;
    repeat (3) pix(8'd0, 1'b0, 1'b0);
    n_cmp++; if (PointValid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_drain: got %0b want 0", PointValid); end
  endtask

`ifdef EDGE_POINT_STATS_EN
  task automatic test_stats;
    PointReady = 1'b0;
    for (int k = 0; k < 300; k++) pix(8'd255, (k == 0), 1'b0);
    n_cmp++; if (Overflow !== 1'b1) begin n_fail++; $display("FAIL stats_ovf_before: got %0b want 1", Overflow); end
    pix(8'd0, 1'b1, 1'b0);
    n_cmp++; if (FrameDone !== 1'b1) begin n_fail++; $display("FAIL stats_frame_done: got %0b want 1", FrameDone); end
    n_cmp++; if (PointCount !== 16'd300) begin n_fail++; $display("FAIL stats_count: got %0d want 300", PointCount); end
    PointReady = 1'b1;
    repeat (18) pix(8'd0, 1'b0, 1'b0);
    n_cmp++; if (PointValid !== 1'b0) begin n_fail++; $display("FAIL stats_drain: got %0b want 0", PointValid); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_point();
    test_threshold();
    test_overflow();
    test_full_push_pop();
    test_saturation();
    test_reset_mid();
`ifdef EDGE_POINT_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
